// File: rtl/md_unit.sv
// rtl/md_unit.sv - execute-stage multiply/divide unit holding the HI/LO registers
//
// Purpose: runs MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, serves
// MTHI/MTLO/MFHI/MFLO and stalls HI/LO-dependent instructions in E while an
// operation is in flight.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   respon         exception response / flush; blocks any accept this cycle
//   E_valid, fire  E holds a valid instruction / it advances this cycle
//   md_use         E instruction is mult/div/mt/mf class
//   start, MDop    start a multiply (00) or divide (01); 1x does nothing
//   MDsign         signed operation
//   mt_we, HIWrite MTHI/MTLO write and its target (1 HI, 0 LO)
//   HIRead         mf source select (1 HI, 0 LO)
//   A, B           rs / rt operands
//   busy           operation in flight
//   md_stall       E must not advance
//   hl_out         HIRead ? HI : LO
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        respon,
    input  logic        E_valid,
    input  logic        fire,
    input  logic        md_use,
    input  logic        start,
    input  logic [1:0]  MDop,
    input  logic        MDsign,
    input  logic        mt_we,
    input  logic        HIWrite,
    input  logic        HIRead,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hl_out
);

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_tmp_hi;
    logic [31:0]      r_tmp_lo;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic        w_accept;
    logic        w_start_mul;
    logic        w_start_div;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_accept    = fire & E_valid & ~respon;
    assign w_start_mul = w_accept & start & (MDop == 2'b00);
    assign w_start_div = w_accept & start & (MDop == 2'b01);

    // Extending to 64 bits and keeping the low half of the product gives the
    // correct two's-complement result for both the signed and unsigned case.
    assign w_prod = (MDsign ? {{32{A[31]}}, A} : {32'd0, A}) *
                    (MDsign ? {{32{B[31]}}, B} : {32'd0, B});

    // Divide on magnitudes, then fix signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally as
    // quotient 0x80000000, remainder 0.
    assign w_a_neg = MDsign & A[31];
    assign w_b_neg = MDsign & B[31];
    assign w_a_mag = w_a_neg ? (32'd0 - A) : A;
    assign w_b_mag = w_b_neg ? (32'd0 - B) : B;

    always_comb begin
        w_q_mag = 32'd0;
        w_r_mag = 32'd0;
        if (B != 32'd0) begin
            w_q_mag = w_a_mag / w_b_mag;
            w_r_mag = w_a_mag % w_b_mag;
        end
    end

    always_comb begin
        w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        if (B == 32'd0) begin
            w_quot = 32'hFFFF_FFFF;
            w_rem  = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_busy) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_hi   <= r_tmp_hi;
                    r_lo   <= r_tmp_lo;
                    r_busy <= 1'b0;
                end
            end
            // Accepts are stalled while busy, so these never race a commit.
            if (w_start_mul) begin
                r_tmp_hi <= w_prod[63:32];
                r_tmp_lo <= w_prod[31:0];
                r_cnt    <= CNT_W'(MUL_CYCLES);
                r_busy   <= 1'b1;
            end else if (w_start_div) begin
                r_tmp_hi <= w_rem;
                r_tmp_lo <= w_quot;
                r_cnt    <= CNT_W'(DIV_CYCLES);
                r_busy   <= 1'b1;
            end
            if (w_accept & mt_we) begin
                if (HIWrite) begin
                    r_hi <= A;
                end else begin
                    r_lo <= A;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign md_stall = E_valid & md_use & r_busy;
    assign hl_out   = HIRead ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, respon, E_valid, fire, md_use, start, MDsign;
    logic        mt_we, HIWrite, HIRead;
    logic [1:0]  MDop;
    logic [31:0] A, B;
    logic        busy, md_stall;
    logic [31:0] hl_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .reset(reset), .respon(respon), .E_valid(E_valid), .fire(fire),
        .md_use(md_use), .start(start), .MDop(MDop), .MDsign(MDsign), .mt_we(mt_we),
        .HIWrite(HIWrite), .HIRead(HIRead), .A(A), .B(B), .busy(busy),
        .md_stall(md_stall), .hl_out(hl_out)
    );

    typedef struct {
        logic [1:0]  mdop;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        respon = 0; E_valid = 0; fire = 0; md_use = 0; start = 0; MDop = 2'b11;
        MDsign = 0; mt_we = 0; HIWrite = 0; A = 0; B = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reads HI and LO through the mf mux; leaves HIRead=0.
    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        HIRead = 1; #1 hi = hl_out;
        HIRead = 0; #1 lo = hl_out;
    endtask

    task automatic check_hl(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi, lo;
        read_hl(hi, lo);
        check({name, ".hi"}, hi, ehi);
        check({name, ".lo"}, lo, elo);
    endtask

    // Reference: arithmetic on 64-bit integers straight from the rules.
    task automatic model(input logic [1:0] op, input logic sign, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
        longint p, sa, sb, q, r;
        longint unsigned up;
        if (op == 2'b00) begin
            if (sign) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = sa * sb;
                hi = p[63:32]; lo = p[31:0];
            end else begin
                up = longint'(a) * longint'(b);
                hi = up[63:32]; lo = up[31:0];
            end
        end else if (b == 0) begin
            lo = 32'hFFFF_FFFF; hi = a;
        end else if (sign) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            lo = q[31:0]; hi = r[31:0];
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    // Issues one start, checks busy and unchanged HI/LO for every cycle of the
    // latency, then checks the commit.
    task automatic run_op(input string name, input logic [1:0] op, input logic sign,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        n = (op == 2'b00) ? 5 : 10;
        E_valid = 1; md_use = 1; fire = 1; start = 1; MDop = op; MDsign = sign; A = a; B = b;
        step();
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            check({name, ".busy_on"}, 32'(busy), 32'd1);
            if (i == n - 1) check_hl({name, ".pre"}, m_hi, m_lo);
            step();
        end
        check({name, ".busy_off"}, 32'(busy), 32'd0);
        m_hi = ehi; m_lo = elo;
        check_hl(name, m_hi, m_lo);
    endtask

    task automatic do_mt(input logic hiw, input logic [31:0] a);
        E_valid = 1; md_use = 1; fire = 1; mt_we = 1; HIWrite = hiw; A = a;
        step();
        idle_inputs();
        if (hiw) m_hi = a; else m_lo = a;
    endtask

    initial begin
        logic [31:0] ehi, elo;
        logic [1:0]  op;
        logic        sg;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b00, 1'b1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{2'b01, 1'b0, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC};
        vecs[2] = '{2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b01, 1'b1, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF};
        vecs[4] = '{2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{2'b01, 1'b0, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'hFFFF_FFFF};
        vecs[7] = '{2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{2'b01, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        idle_inputs();
        HIRead = 0;
        reset = 1;
        step(); step();
        reset = 0;
        m_hi = 0; m_lo = 0;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.stall", 32'(md_stall), 32'd0);
        check_hl("reset", 32'd0, 32'd0);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].mdop, vecs[i].sign, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);

        // MDop=1x with start does nothing.
        E_valid = 1; md_use = 1; fire = 1; start = 1; MDop = 2'b10; A = 32'h1111; B = 32'h2222;
        step();
        idle_inputs();
        check("nop.busy", 32'(busy), 32'd0);
        check_hl("nop", m_hi, m_lo);

        // MULTU then MFLO waiting in E: stalled for the whole latency.
        E_valid = 1; md_use = 1; fire = 1; start = 1; MDop = 2'b00; A = 32'h0001_0000; B = 32'h0001_0000;
        step();
        idle_inputs();
        E_valid = 1; md_use = 1; HIRead = 0;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("mf_stall.c%0d", i), 32'(md_stall), 32'd1);
            step();
        end
        check("mf_stall.drop", 32'(md_stall), 32'd0);
        check("mf_stall.lo", hl_out, 32'd0);
        HIRead = 1; #1;
        check("mf_stall.hi", hl_out, 32'd1);
        m_hi = 1; m_lo = 0;
        fire = 1; step(); idle_inputs(); HIRead = 0;

        // MTHI then MFHI the next instruction.
        do_mt(1'b1, 32'h1234_5678);
        E_valid = 1; md_use = 1; HIRead = 1; #1;
        check("mthi.hl_out", hl_out, 32'h1234_5678);
        check("mthi.stall", 32'(md_stall), 32'd0);
        fire = 1; step(); idle_inputs();
        check_hl("mthi", 32'h1234_5678, m_lo);

        // Start blocked by respon.
        E_valid = 1; md_use = 1; fire = 1; start = 1; MDop = 2'b00; MDsign = 1; A = 32'd9; B = 32'd9;
        respon = 1;
        step();
        idle_inputs();
        check("respon.busy", 32'(busy), 32'd0);
        check_hl("respon", m_hi, m_lo);

        // In-flight MULT survives a respon pulse during the count.
        E_valid = 1; md_use = 1; fire = 1; start = 1; MDop = 2'b00; MDsign = 1; A = 32'd100; B = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            respon = (i == 1);
            check($sformatf("respon_fly.busy%0d", i), 32'(busy), 32'd1);
            step();
        end
        respon = 0;
        check("respon_fly.done", 32'(busy), 32'd0);
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FF9C;
        check_hl("respon_fly", m_hi, m_lo);

        // Reset during cycle 3 of a DIV discards the pending commit.
        E_valid = 1; md_use = 1; fire = 1; start = 1; MDop = 2'b01; A = 32'd50; B = 32'd7;
        step();
        idle_inputs();
        step(); step();
        reset = 1;
        step();
        reset = 0;
        m_hi = 0; m_lo = 0;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check_hl("rst_mid", 32'd0, 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("rst_mid.late_busy", 32'(busy), 32'd0);
        check_hl("rst_mid.late", 32'd0, 32'd0);

        // Random operations and moves against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 17));
                3: do_mt(1'b0, $urandom());
                default: ;
            endcase
            model(op, sg, ra, rb, ehi, elo);
            run_op($sformatf("rnd%0d", i), op, sg, ra, rb, ehi, elo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit.
- Sits directly downstream of the E pipeline register and consumes its decoded start/MDop/MDsign/HIWrite/HIRead controls and the rs/rt operands.
- Holds the architectural HI/LO registers, runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and serves MTHI/MTLO/MFHI/MFLO.
- Raises a stall so that HI/LO-dependent instructions cannot leave E while an operation is in flight.

Parameters:
MUL_CYCLES, 5, busy cycles for a multiply (>=1)
DIV_CYCLES, 10, busy cycles for a divide (>=1)
CNT_W, 4, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
respon  input  1  exception response / pipeline flush this cycle
E_valid  input  1  E stage holds a valid instruction
fire  input  1  E instruction advances to M this cycle (E_valid & ready_go & M_allowin)
md_use  input  1  E instruction is mult/div/mt/mf class
start  input  1  E instruction is MULT/MULTU/DIV/DIVU
MDop  input  2  00 multiply, 01 divide, 1x no operation
MDsign  input  1  1 signed, 0 unsigned
mt_we  input  1  E instruction is MTHI/MTLO
HIWrite  input  1  mt target: 1 HI, 0 LO
HIRead  input  1  mf source: 1 HI, 0 LO
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
busy  output  1  operation in flight
md_stall  output  1  E must not advance
hl_out  output  32  HIRead ? HI : LO

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, result temps=0, md_stall=0.
- Accept condition: accept = fire & E_valid & ~respon. Nothing is accepted while respon=1.
- Start:
  - On accept & start & MDop[1]==0, capture the result into temps at that edge.
  - Multiply result is the 64-bit product. Signed when MDsign=1; operands are zero-extended when MDsign=0.
  - Divide result is the quotient and remainder. Signed divide truncates toward zero and the remainder takes the dividend's sign.
  - The edge loads counter = MUL_CYCLES or DIV_CYCLES and sets busy=1.
  - MDop=1x with start: no effect.
- Count:
  - While busy, decrement the counter each cycle.
  - In the cycle the counter==1, the next edge commits the temps: multiply gives HI=prod[63:32], LO=prod[31:0]; divide gives LO=quotient, HI=remainder. The same edge clears busy.
  - A start issued at edge t therefore commits at edge t+N. busy is high for exactly N cycles.
- Divide by zero: LO=0xFFFFFFFF, HI=A. The same latency applies.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MT: on accept & mt_we, the next edge writes A into HI (HIWrite=1) or LO (HIWrite=0). Takes effect immediately with no busy.
- MF: hl_out is combinational from the current HI/LO.
- Stall: md_stall = E_valid & md_use & busy. It is combinational and does not depend on fire, so there is no loop.
  - A new start, mt, or mf never coincides with busy=1 at accept, because it is stalled.
  - Consequence: a start issued by the instruction leaving E cannot be accepted twice.
- respon:
  - Blocks any new accept in that cycle.
  - Does not abort an in-flight operation. That operation belongs to an instruction already past E, so it completes and commits normally.
- Commit and accept on the same edge: impossible, because any accept requires busy=0 and a commit only happens while busy=1.
- Reset mid-operation: all state returns to reset values and the pending commit is discarded.

Test Plan:
1. Signed MULT, A=0xFFFFFFFE (-2), B=3, one-cycle fire:
   - busy is high for 5 cycles.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
   - HI/LO are unchanged before the commit edge.
2. Unsigned vs signed divide with A=0xFFFFFFF9, B=2:
   - DIVU gives LO=0x7FFFFFFC, HI=1, busy for 10 cycles.
   - Signed DIV (A=-7, B=2) gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIV by 0 with A=5 gives LO=0xFFFFFFFF, HI=5.
3. MULTU 0x10000 x 0x10000 followed by MFLO with md_use=1, E_valid=1:
   - md_stall=1 for cycles 1-5 after the start.
   - It drops the cycle busy clears, and hl_out=0 (LO); HI=1.
4. MTHI A=0x12345678, then MFHI next instruction:
   - hl_out=0x12345678 one cycle later.
   - No stall; LO is unchanged.
5. Start with respon=1 in the same cycle:
   - No busy, HI/LO unchanged.
   - A MULT accepted the previous cycle still commits after 5 cycles even though respon pulses during the count.
6. Reset asserted on cycle 3 of a DIV:
   - busy=0, HI=LO=0 next cycle.
   - No later commit occurs.
